// File: rtl/instr_mem_arbiter_pkg.sv
// Shared definitions for the instruction memory arbiter slice.
package instr_mem_pkg;

  // Requester identity, used for grant winner and read-response ownership.
  typedef enum logic {
    REQ_HOST = 1'b0,
    REQ_CPU  = 1'b1
  } req_id_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_LOCK_MAX   = 16;
  localparam int STALL_W        = 16;
  localparam int LOCK_CNT_W     = 8;

endpackage

// File: rtl/instr_mem_arbiter_if.sv
// Host, CPU fetch and memory-side signals of the arbiter grouped as one bundle.
// slave  : the arbiter itself.
// master : the requesters plus the memory array (the arbiter's environment).
interface instr_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                    h_req;
  logic                    h_we;
  logic                    h_lock;
  logic [ADDR_WIDTH-1:0]   h_addr;
  logic [DATA_WIDTH-1:0]   h_wdata;
  logic [DATA_WIDTH/8-1:0] h_wstrb;
  logic                    h_gnt;
  logic                    h_rvalid;
  logic [DATA_WIDTH-1:0]   h_rdata;

  logic                    c_req;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic                    c_gnt;
  logic                    c_rvalid;
  logic [DATA_WIDTH-1:0]   c_rdata;

  logic                    mem_en;
  logic [DATA_WIDTH/8-1:0] mem_wstrb;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  h_req, h_we, h_lock, h_addr, h_wdata, h_wstrb,
    input  c_req, c_addr,
    input  mem_rdata,
    output h_gnt, h_rvalid, h_rdata,
    output c_gnt, c_rvalid, c_rdata,
    output mem_en, mem_wstrb, mem_addr, mem_wdata
  );

  modport master (
    output h_req, h_we, h_lock, h_addr, h_wdata, h_wstrb,
    output c_req, c_addr,
    output mem_rdata,
    input  h_gnt, h_rvalid, h_rdata,
    input  c_gnt, c_rvalid, c_rdata,
    input  mem_en, mem_wstrb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_mem_arbiter_rr_arb2.sv
// Two-way round-robin grant with host lock override.
// The grant is combinational; only the last winner is stored.
module rr_arb2
  import instr_mem_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    h_req_i,
  input  logic    c_req_i,
  input  logic    lock_win_i,
  output logic    valid_o,
  output req_id_e winner_o
);

  req_id_e last_winner_q, last_winner_d;

  // Pick a winner: single requester wins outright, ties go to lock then to the non-last winner.
  always_comb begin
    valid_o       = 1'b0;
    winner_o      = REQ_HOST;
    if (h_req_i && c_req_i) begin
      valid_o = 1'b1;
      if (lock_win_i) begin
        winner_o = REQ_HOST;
      end else begin
        winner_o = (last_winner_q == REQ_HOST) ? REQ_CPU : REQ_HOST;
      end
    end else if (h_req_i) begin
      valid_o  = 1'b1;
      winner_o = REQ_HOST;
    end else if (c_req_i) begin
      valid_o  = 1'b1;
      winner_o = REQ_CPU;
    end
    last_winner_d = valid_o ? winner_o : last_winner_q;
  end

  // Remember every winner, locked host grants included, so the CPU takes the first tie after a lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_winner_q <= REQ_HOST;
    else         last_winner_q <= last_winner_d;
  end

endmodule

// File: rtl/instr_mem_arbiter.sv
// Shares one single-port synchronous memory between the AXI host side and the CPU fetch port.
// One access per cycle, fixed 1-cycle read latency, responses steered back to their owner.
module instr_mem_arbiter
  import instr_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LOCK_MAX   = DEF_LOCK_MAX
)(
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  instr_mem_if.slave         bus,
  output logic [STALL_W-1:0] c_stall_cnt
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_MAX_C = LOCK_CNT_W'(LOCK_MAX);
  localparam logic [STALL_W-1:0]    STALL_SAT  = '1;

  logic                  arb_valid;
  req_id_e               arb_winner;
  logic                  gnt_any;
  logic                  host_gnt;
  logic                  cpu_gnt;
  logic                  lock_win;
  logic                  rd_issue;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0] rdata_w;

  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  req_id_e               rd_sel_q, rd_sel_d;
  logic [STALL_W-1:0]    stall_q, stall_d;

  assign lock_win = bus.h_lock && (lock_cnt_q < LOCK_MAX_C);

  rr_arb2 u_arb (
    .clk_i      (S_AXI_ACLK),
    .rst_ni     (S_AXI_ARESETN),
    .h_req_i    (bus.h_req),
    .c_req_i    (bus.c_req),
    .lock_win_i (lock_win),
    .valid_o    (arb_valid),
    .winner_o   (arb_winner)
  );

  // Grants are gated by reset so that nothing reaches the memory while reset is held.
  assign gnt_any  = arb_valid && S_AXI_ARESETN;
  assign host_gnt = gnt_any && (arb_winner == REQ_HOST);
  assign cpu_gnt  = gnt_any && (arb_winner == REQ_CPU);
  assign rd_issue = cpu_gnt || (host_gnt && !bus.h_we);

  assign addr_w  = (arb_winner == REQ_CPU) ? bus.c_addr : bus.h_addr;
  assign rdata_w = bus.mem_rdata;

  assign bus.h_gnt     = host_gnt;
  assign bus.c_gnt     = cpu_gnt;
  assign bus.mem_en    = gnt_any;
  assign bus.mem_addr  = addr_w;
  assign bus.mem_wdata = bus.h_wdata;
  assign bus.mem_wstrb = (host_gnt && bus.h_we) ? bus.h_wstrb : '0;

  assign bus.h_rvalid = rd_pend_q && (rd_sel_q == REQ_HOST);
  assign bus.c_rvalid = rd_pend_q && (rd_sel_q == REQ_CPU);
  assign bus.h_rdata  = rdata_w;
  assign bus.c_rdata  = rdata_w;

  assign c_stall_cnt = stall_q;

  // Next-state for lock counter, read-response tracking and CPU stall counter.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!bus.h_lock) begin
      lock_cnt_d = '0;
    end else if (cpu_gnt && (lock_cnt_q == LOCK_MAX_C)) begin
      lock_cnt_d = '0;
    end else if (host_gnt && bus.c_req && (lock_cnt_q < LOCK_MAX_C)) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end

    rd_pend_d = rd_issue;
    rd_sel_d  = rd_issue ? arb_winner : rd_sel_q;

    stall_d = stall_q;
    if (bus.c_req && !cpu_gnt && (stall_q != STALL_SAT)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // State registers; reset also drops any read still in flight.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_sel_q   <= REQ_HOST;
      stall_q    <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_sel_q   <= rd_sel_d;
      stall_q    <= stall_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter (LOCK_MAX overridden to 4).
// Memory contents start as 32'h1000_0000 + addr*32'h0101.
module tb_instr_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] stall;
  int          checks = 0;
  int          failures = 0;

  logic [31:0] mem [256];
  bit          mem_init = 1'b0;

  logic        h_wait = 1'b0;
  logic [7:0]  h_addr_p;
  logic        h_we_p;
  logic [31:0] h_wdata_p;

  logic [20:0] lock_pat;
  logic        exp_cpu;

  instr_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  instr_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LOCK_MAX(4)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .bus           (bus),
    .c_stall_cnt   (stall)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory model with byte strobes.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i) * 32'h0101;
      mem_init <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_wstrb != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wstrb[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr];
      end
    end
  end

  // Host must hold its fields while waiting for a grant.
  always @(posedge clk) begin
    if (rst_n && h_wait && bus.h_req) begin
      assert (bus.h_addr === h_addr_p && bus.h_we === h_we_p && bus.h_wdata === h_wdata_p)
      else begin
        failures++;
        $error("FAIL host_protocol observed addr=%h expected addr=%h", bus.h_addr, h_addr_p);
      end
    end
    h_wait    <= rst_n && bus.h_req && !bus.h_gnt;
    h_addr_p  <= bus.h_addr;
    h_we_p    <= bus.h_we;
    h_wdata_p <= bus.h_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.h_req = 1'b0; bus.h_we = 1'b0; bus.h_lock = 1'b0;
    bus.h_addr = 8'h00; bus.h_wdata = 32'h0; bus.h_wstrb = 4'h0;
    bus.c_req = 1'b0; bus.c_addr = 8'h00;
    lock_pat = 21'h10_4210;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_h_gnt", 32'(bus.h_gnt), 32'd0);
    chk("rst_c_gnt", 32'(bus.c_gnt), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("rst_h_rvalid", 32'(bus.h_rvalid), 32'd0);
    chk("rst_c_rvalid", 32'(bus.c_rvalid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // CPU-only reads at 0,1,2 back to back
    @(negedge clk); bus.c_req = 1'b1; bus.c_addr = 8'h00; #1;
    chk("cpu0_gnt", 32'(bus.c_gnt), 32'd1);
    chk("cpu0_h_gnt", 32'(bus.h_gnt), 32'd0);
    chk("cpu0_addr", 32'(bus.mem_addr), 32'h00);
    chk("cpu0_wstrb", 32'(bus.mem_wstrb), 32'd0);
    @(negedge clk); bus.c_addr = 8'h01; #1;
    chk("cpu1_gnt", 32'(bus.c_gnt), 32'd1);
    chk("cpu1_addr", 32'(bus.mem_addr), 32'h01);
    chk("cpu0_rvalid", 32'(bus.c_rvalid), 32'd1);
    chk("cpu0_rdata", bus.c_rdata, 32'h1000_0000);
    chk("cpu0_h_rvalid", 32'(bus.h_rvalid), 32'd0);
    @(negedge clk); bus.c_addr = 8'h02; #1;
    chk("cpu1_rvalid", 32'(bus.c_rvalid), 32'd1);
    chk("cpu1_rdata", bus.c_rdata, 32'h1000_0101);
    @(negedge clk); bus.c_req = 1'b0; #1;
    chk("cpu_idle_mem_en", 32'(bus.mem_en), 32'd0);
    chk("cpu2_rvalid", 32'(bus.c_rvalid), 32'd1);
    chk("cpu2_rdata", bus.c_rdata, 32'h1000_0202);
    @(negedge clk); #1;
    chk("cpu_rvalid_pulse", 32'(bus.c_rvalid), 32'd0);
    chk("cpu_only_stall", 32'(stall), 32'd0);

    // Host partial write then read-back
    @(negedge clk);
    bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 8'h10;
    bus.h_wdata = 32'hDEAD_BEEF; bus.h_wstrb = 4'b0011; #1;
    chk("hw_gnt", 32'(bus.h_gnt), 32'd1);
    chk("hw_wstrb", 32'(bus.mem_wstrb), 32'h3);
    chk("hw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("hw_addr", 32'(bus.mem_addr), 32'h10);
    @(negedge clk); bus.h_we = 1'b0; #1;
    chk("hw_no_rvalid", 32'(bus.h_rvalid), 32'd0);
    chk("hr_gnt", 32'(bus.h_gnt), 32'd1);
    chk("hr_wstrb", 32'(bus.mem_wstrb), 32'd0);
    @(negedge clk); bus.h_req = 1'b0; #1;
    chk("hr_rvalid", 32'(bus.h_rvalid), 32'd1);
    chk("hr_rdata", bus.h_rdata, 32'h1000_BEEF);
    chk("hr_c_rvalid", 32'(bus.c_rvalid), 32'd0);

    // Fresh reset, then both requesting with no lock: alternate, CPU first
    @(negedge clk); rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 8'h20;
        bus.c_req = 1'b1; bus.c_addr = 8'h01;
      end
      #1;
      exp_cpu = (k % 2 == 0);
      chk("rr_c_gnt", 32'(bus.c_gnt), 32'(exp_cpu));
      chk("rr_h_gnt", 32'(bus.h_gnt), 32'(!exp_cpu));
      chk("rr_stall", 32'(stall), 32'(k / 2));
      if (k > 0) begin
        chk("rr_c_rvalid", 32'(bus.c_rvalid), 32'(!exp_cpu));
        chk("rr_h_rvalid", 32'(bus.h_rvalid), 32'(exp_cpu));
        chk("rr_rdata", exp_cpu ? bus.h_rdata : bus.c_rdata,
            exp_cpu ? 32'h1000_2020 : 32'h1000_0101);
      end
    end
    @(negedge clk); bus.h_req = 1'b0; bus.c_req = 1'b0; #1;
    chk("rr_last_h_rvalid", 32'(bus.h_rvalid), 32'd1);
    chk("rr_last_rdata", bus.h_rdata, 32'h1000_2020);
    chk("rr_stall_end", 32'(stall), 32'd3);

    // Host lock with LOCK_MAX=4, then lock release and re-lock
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      bus.h_req = 1'b1; bus.c_req = 1'b1;
      bus.h_lock = (k < 14) || (k >= 16);
      #1;
      chk("lock_c_gnt", 32'(bus.c_gnt), 32'(lock_pat[k]));
      chk("lock_h_gnt", 32'(bus.h_gnt), 32'(!lock_pat[k]));
      if (k > 0) chk("lock_c_rvalid", 32'(bus.c_rvalid), 32'(lock_pat[k-1]));
    end
    @(negedge clk); bus.h_req = 1'b0; bus.c_req = 1'b0; bus.h_lock = 1'b0;

    // Reset the cycle after a CPU read grant
    @(negedge clk); bus.c_req = 1'b1; bus.c_addr = 8'h02; #1;
    chk("rst_rd_gnt", 32'(bus.c_gnt), 32'd1);
    @(negedge clk); bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 8'h20; rst_n = 1'b0; #1;
    chk("rst_async_c_rvalid", 32'(bus.c_rvalid), 32'd0);
    chk("rst_async_c_gnt", 32'(bus.c_gnt), 32'd0);
    chk("rst_async_h_gnt", 32'(bus.h_gnt), 32'd0);
    chk("rst_async_mem_en", 32'(bus.mem_en), 32'd0);
    @(negedge clk); #1;
    chk("rst_hold_c_rvalid", 32'(bus.c_rvalid), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_tie_c_gnt", 32'(bus.c_gnt), 32'd1);
    chk("rst_tie_h_gnt", 32'(bus.h_gnt), 32'd0);
    chk("rst_rel_c_rvalid", 32'(bus.c_rvalid), 32'd0);

    // Stall counter saturation with the CPU grant stubbed off
    @(negedge clk); rst_n = 1'b0; bus.h_req = 1'b0; bus.c_req = 1'b1;
    force dut.cpu_gnt = 1'b0;
    #1;
    @(negedge clk); rst_n = 1'b1; #1;
    chk("sat_start", 32'(stall), 32'd0);
    repeat (65534) @(negedge clk);
    #1;
    chk("sat_fffe", 32'(stall), 32'h0000_FFFE);
    @(negedge clk); #1;
    chk("sat_ffff", 32'(stall), 32'h0000_FFFF);
    repeat (3) @(negedge clk);
    #1;
    chk("sat_hold", 32'(stall), 32'h0000_FFFF);
    release dut.cpu_gnt;
    bus.c_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
